// File: rtl/rx_pkt_store.sv
// Receive-side frame bookkeeping: counts bytes written into an external FIFO while carrier
// is present, then tracks the frame as it is read out, dropping runts and oversized frames.
// Optional frame statistics are built only when RX_STORE_STATS_EN is defined.
module rx_pkt_store #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_LEN   = 255,
  parameter int unsigned MIN_LEN   = 1,
  parameter int unsigned CTRL_TAIL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             cardet,
  input  logic [7:0]       pkt_type,
  input  logic             read,
  input  logic             RRDY,
  input  logic             fifo_empty,
  output logic             done_reading,
  output logic             flush,
  output logic [CNT_W-1:0] byte_count,
  output logic             overflow,
  output logic [15:0]      pkt_count,
  output logic [15:0]      drop_count
);

  localparam logic [CNT_W-1:0] MaxLen   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MinLen   = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CtrlTail = CNT_W'(CTRL_TAIL);
  localparam logic [CNT_W-1:0] One      = CNT_W'(1);
  localparam logic [7:0]       TypeData = 8'h30;  // ASCII "0"

  typedef enum logic [2:0] {StIdle, StWriting, StReading, StDrop, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             complete;

  // Frame fully consumed: FIFO ran dry, or a control frame reached its tail count.
  assign complete = (state_q == StReading) &&
                    (fifo_empty || ((pkt_type != TypeData) && (count_q <= CtrlTail)));

  assign done_reading = complete || (state_q == StDone);
  assign flush        = (state_q == StDrop);
  assign byte_count   = count_q;
  assign overflow     = overflow_q;

  // Frame FSM together with its byte counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_q    <= '0;
          overflow_q <= 1'b0;
          if (cardet) state_q <= StWriting;
        end
        StWriting: begin
          if (!cardet) begin
            // Empty frames vanish silently; bad frames must be flushed from the FIFO.
            if (count_q == '0)                            state_q <= StIdle;
            else if (overflow_q || (count_q < MinLen))    state_q <= StDrop;
            else                                          state_q <= StReading;
          end else if (write) begin
            if (count_q == MaxLen) overflow_q <= 1'b1;
            else                   count_q    <= count_q + One;
          end
        end
        StReading: begin
          // Decrement still applies on the completing cycle.
          if (read && (count_q != '0)) count_q <= count_q - One;
          if (complete) state_q <= StDone;
        end
        StDrop: state_q <= StIdle;
        StDone: if (!RRDY) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RX_STORE_STATS_EN
  logic [15:0] pkt_count_q;
  logic [15:0] drop_count_q;

  // Wrapping delivered/dropped frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (complete)           pkt_count_q  <= pkt_count_q + 16'd1;
      if (state_q == StDrop)  drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_rx_pkt_store.sv
// Directed bench for rx_pkt_store: a default instance for data/control/reset frames and a
// small instance (MAX_LEN=4, MIN_LEN=3) for overflow and runt drops. Both share stimulus.
module tb_rx_pkt_store;

`ifdef RX_STORE_STATS_EN
  localparam int unsigned StatsOn = 1;
`else
  localparam int unsigned StatsOn = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write = 1'b0;
  logic       cardet = 1'b0;
  logic [7:0] pkt_type = 8'h30;
  logic       read = 1'b0;
  logic       RRDY = 1'b0;
  logic       fifo_empty = 1'b0;

  logic       d0_done, d0_flush, d0_ovf;
  logic [7:0] d0_cnt;
  logic [15:0] d0_pkt, d0_drop;
  logic       d1_done, d1_flush, d1_ovf;
  logic [7:0] d1_cnt;
  logic [15:0] d1_pkt, d1_drop;

  int vectors = 0;
  int miscompares = 0;

  rx_pkt_store dut0 (
    .clk(clk), .reset(reset), .write(write), .cardet(cardet), .pkt_type(pkt_type),
    .read(read), .RRDY(RRDY), .fifo_empty(fifo_empty), .done_reading(d0_done),
    .flush(d0_flush), .byte_count(d0_cnt), .overflow(d0_ovf), .pkt_count(d0_pkt),
    .drop_count(d0_drop)
  );

  rx_pkt_store #(.CNT_W(8), .MAX_LEN(4), .MIN_LEN(3), .CTRL_TAIL(1)) dut1 (
    .clk(clk), .reset(reset), .write(write), .cardet(cardet), .pkt_type(pkt_type),
    .read(read), .RRDY(RRDY), .fifo_empty(fifo_empty), .done_reading(d1_done),
    .flush(d1_flush), .byte_count(d1_cnt), .overflow(d1_ovf), .pkt_count(d1_pkt),
    .drop_count(d1_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; write = 1'b0; cardet = 1'b0; read = 1'b0; RRDY = 1'b0;
    fifo_empty = 1'b0; pkt_type = 8'h30;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    settle();
    chk("rst_cnt", 32'(d0_cnt), 0);
    chk("rst_ovf", 32'(d0_ovf), 0);
    chk("rst_done", 32'(d0_done), 0);
    chk("rst_flush", 32'(d0_flush), 0);
    chk("rst_pkt", 32'(d0_pkt), 0);
    chk("rst_drop", 32'(d0_drop), 0);

    // Data frame: 10 bytes in, 10 bytes out, then FIFO empty
    cardet = 1'b1;
    tick();
    write = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("data_cnt_full", 32'(d0_cnt), 10);
    write = 1'b0; cardet = 1'b0;
    tick();
    settle();
    chk("data_read_start_cnt", 32'(d0_cnt), 10);
    chk("data_read_start_done", 32'(d0_done), 0);
    read = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("data_cnt_drained", 32'(d0_cnt), 0);
    chk("data_done_before_empty", 32'(d0_done), 0);
    read = 1'b0; fifo_empty = 1'b1;
    settle();
    chk("data_done_comb", 32'(d0_done), 1);
    tick();
    fifo_empty = 1'b0;
    settle();
    chk("data_done_state", 32'(d0_done), 1);
    chk("data_pkt", 32'(d0_pkt), StatsOn);
    chk("data_noflush", 32'(d0_flush), 0);
    tick();
    chk("data_back_idle", 32'(d0_done), 0);

    // Control frame "A": completes when byte_count reaches 1, RRDY holds DONE
    do_reset();
    pkt_type = 8'h41; cardet = 1'b1;
    tick();
    write = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    write = 1'b0; cardet = 1'b0;
    tick();
    settle();
    chk("ctrl_cnt3_done", 32'(d0_done), 0);
    read = 1'b1;
    tick();
    chk("ctrl_cnt2", 32'(d0_cnt), 2);
    chk("ctrl_cnt2_done", 32'(d0_done), 0);
    tick();
    chk("ctrl_cnt1", 32'(d0_cnt), 1);
    chk("ctrl_cnt1_done", 32'(d0_done), 1);
    RRDY = 1'b1;
    tick();
    read = 1'b0;
    settle();
    chk("ctrl_dec_on_done", 32'(d0_cnt), 0);
    chk("ctrl_done_state", 32'(d0_done), 1);
    chk("ctrl_pkt", 32'(d0_pkt), StatsOn);
    tick();
    chk("ctrl_hold1", 32'(d0_done), 1);
    tick();
    chk("ctrl_hold2", 32'(d0_done), 1);
    RRDY = 1'b0;
    settle();
    chk("ctrl_rrdy_low_still_done", 32'(d0_done), 1);
    tick();
    chk("ctrl_exit_idle", 32'(d0_done), 0);

    // Overflow on the small instance: 6 writes into MAX_LEN=4
    do_reset();
    cardet = 1'b1;
    tick();
    write = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("ovf_cnt_sat", 32'(d1_cnt), 4);
    chk("ovf_flag", 32'(d1_ovf), 1);
    write = 1'b0; cardet = 1'b0;
    settle();
    chk("ovf_flush_pre", 32'(d1_flush), 0);
    tick();
    chk("ovf_flush", 32'(d1_flush), 1);
    chk("ovf_nodone", 32'(d1_done), 0);
    chk("ovf_cnt_drop", 32'(d1_cnt), 4);
    tick();
    chk("ovf_flush_once", 32'(d1_flush), 0);
    chk("ovf_drop", 32'(d1_drop), StatsOn);
    chk("ovf_nodone_idle", 32'(d1_done), 0);
    tick();
    chk("ovf_cleared", 32'(d1_ovf), 0);
    chk("ovf_cnt_cleared", 32'(d1_cnt), 0);

    // Runt frame (2 < MIN_LEN=3) then an empty frame
    do_reset();
    cardet = 1'b1;
    tick();
    write = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    write = 1'b0; cardet = 1'b0;
    tick();
    chk("runt_flush", 32'(d1_flush), 1);
    tick();
    chk("runt_flush_once", 32'(d1_flush), 0);
    chk("runt_drop", 32'(d1_drop), StatsOn);
    cardet = 1'b1;
    tick();
    cardet = 1'b0;
    tick();
    chk("empty_noflush", 32'(d1_flush), 0);
    tick();
    chk("empty_noflush2", 32'(d1_flush), 0);
    chk("empty_drop_same", 32'(d1_drop), StatsOn);
    chk("empty_pkt_same", 32'(d1_pkt), 0);

    // Reset mid-WRITING, then a 2-byte data frame
    do_reset();
    cardet = 1'b1;
    tick();
    write = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_cnt5", 32'(d0_cnt), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0; write = 1'b0;
    settle();
    chk("midrst_cnt", 32'(d0_cnt), 0);
    chk("midrst_flush", 32'(d0_flush), 0);
    chk("midrst_pkt", 32'(d0_pkt), 0);
    chk("midrst_drop", 32'(d0_drop), 0);
    tick();
    write = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    chk("post_cnt2", 32'(d0_cnt), 2);
    write = 1'b0; cardet = 1'b0;
    tick();
    read = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    read = 1'b0; fifo_empty = 1'b1;
    settle();
    chk("post_done", 32'(d0_done), 1);
    chk("post_cnt0", 32'(d0_cnt), 0);
    tick();
    fifo_empty = 1'b0;
    settle();
    chk("post_pkt", 32'(d0_pkt), StatsOn);
    tick();
    chk("post_idle", 32'(d0_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_pkt_store.md
RX_PKT_STORE -- requirements
Module: rx_pkt_store

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL expose CNT_W, default 8, width of the byte counter.
REQ-002 The block SHALL expose MAX_LEN, default 255, maximum bytes per frame (MAX_LEN <= 2^CNT_W-1).
REQ-003 The block SHALL expose MIN_LEN, default 1, minimum bytes for a frame to be kept.
REQ-004 The block SHALL expose CTRL_TAIL, default 1, remaining count at which a control frame (pkt_type != "0") completes.
Ports (name, direction, width, meaning):
REQ-005 clk, in, 1, the only clock; reset, in, 1, synchronous active-high reset.
REQ-006 write, in, 1, one byte stored to the FIFO this cycle; cardet, in, 1, carrier detect.
REQ-007 pkt_type, in, 8, ASCII frame type; "0" is data, any other value is control.
REQ-008 read, in, 1, one byte popped from the FIFO this cycle; RRDY, in, 1, consumer ready/holding; fifo_empty, in, 1, FIFO empty.
REQ-009 done_reading, out, 1, frame fully consumed; flush, out, 1, one-cycle FIFO flush request.
REQ-010 byte_count, out, CNT_W, bytes remaining in the current frame; overflow, out, 1, current frame exceeded MAX_LEN.
REQ-011 pkt_count, out, 16, frames delivered; drop_count, out, 16, frames dropped (see Configuration).

Function
REQ-012 The FSM SHALL have the states IDLE, WRITING, READING, DROP and DONE, all registered on posedge clk.
REQ-013 IDLE: byte_count=0 and overflow=0; cardet=1 -> WRITING on the next cycle; otherwise stay.
REQ-014 WRITING: each cycle with write=1 and cardet=1, byte_count increments by 1, saturating at MAX_LEN; a write at MAX_LEN sets overflow (sticky until IDLE).
REQ-015 WRITING: on cardet=0, byte_count=0 -> IDLE; overflow=1 or byte_count<MIN_LEN -> DROP; otherwise -> READING; a write in the cardet=0 cycle is not counted.
REQ-016 DROP: flush=1 for exactly one cycle, drop_count increments, next -> IDLE.
REQ-017 READING: read=1 decrements byte_count, floored at 0; write is ignored.
REQ-018 READING: if fifo_empty=1, or pkt_type!="0" and byte_count<=CTRL_TAIL, done_reading=1 combinationally in that cycle, pkt_count increments, next -> DONE.
REQ-019 DONE: done_reading=1; RRDY=1 holds DONE; RRDY=0 -> IDLE.
REQ-020 cardet is ignored in READING, DROP and DONE; a new frame is only accepted from IDLE.
REQ-021 If read and the completion condition occur in the same READING cycle, the decrement SHALL apply before entering DONE.
REQ-022 done_reading and flush SHALL never be asserted in the same cycle.

Reset
REQ-023 With reset=1 at posedge clk: state=IDLE, byte_count=0, overflow=0, pkt_count=0, drop_count=0; done_reading and flush are 0 in the following cycle.
REQ-024 Reset SHALL take priority over every input in every state, including mid-WRITING and mid-READING, and SHALL NOT assert flush.

Configuration
REQ-025 Macro RX_STORE_STATS_EN: when defined, pkt_count and drop_count are 16-bit wrapping counters as specified above.
REQ-026 Without RX_STORE_STATS_EN, pkt_count and drop_count SHALL be constant 0 and no counter registers are built; all other behaviour is unchanged.

Verification
REQ-027 Data frame: cardet high, 10 writes, cardet low, then 10 reads with fifo_empty asserted after the 10th -> byte_count 10->0; done_reading=1; pkt_count=1.
REQ-028 Control frame: pkt_type="A", 3 writes, then reads -> done_reading asserts in the cycle byte_count==1 with fifo_empty=0; DONE is held while RRDY=1 and exits to IDLE one cycle after RRDY=0.
REQ-029 Overflow: MAX_LEN=4, 6 writes, cardet low -> byte_count stays 4, overflow=1, DROP, flush high for 1 cycle, drop_count=1, done_reading never asserted.
REQ-030 Runt frame: MIN_LEN=3, 2 writes -> DROP and flush; zero writes -> IDLE with no flush and no count change.
REQ-031 Reset asserted after 5 writes in WRITING -> next cycle IDLE, byte_count=0, stats=0, no flush; a subsequent 2-byte frame completes normally.
REQ-032 Build without RX_STORE_STATS_EN, rerun REQ-027 -> identical done_reading timing; pkt_count=0.
